bcd_serial_adder_ctrl: RTL and testbench
========================================

# bcd_serial_adder_ctrl

Digit-serial controller for a multi-digit packed-BCD adder. It accepts two DIGITS-digit BCD operands and a carry-in with a start/done handshake. It time-shares a single 1-digit BCD add-and-correct stage across all digits, least significant digit first, one digit per clock. It is the sequencing block that lets wide BCD additions run on one digit slice instead of a DIGITS-wide ripple chain.

## Interface
- DIGITS, 3, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  packed BCD operand, digit 0 = a[3:0]
- b  input  4*DIGITS  packed BCD operand, same packing
- cin  input  1  carry into digit 0
- busy  output  1  high while digits are being processed (ADD state)
- done  output  1  one-cycle pulse: s/cout/err valid
- s  output  4*DIGITS  packed BCD sum
- cout  output  1  carry out of most significant digit
- err  output  1  an input digit of a or b was >9

## Operation
- States: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE: if start=1, capture a, b and cin into internal shift registers, clear the digit counter and the internal sum accumulator, and go to ADD. If start=0, remain in IDLE.
- ADD: each cycle processes digit k, where k is the counter value:
  - t = a_k + b_k + c, computed 5 bits wide; c is the running carry register.
  - if t > 9, u = (t + 6) mod 32; otherwise u = t.
  - sum digit k = u[3:0]; next c = u[4].
  - if a_k > 9 or b_k > 9, set a sticky error bit.
  - The operand registers shift right 4 bits. u[3:0] is shifted into the accumulator at the top, so after DIGITS shifts digit 0 ends at bits [3:0].
  - When k = DIGITS−1, go to DONE; otherwise increment k.
- DONE: load s ← accumulator, cout ← c, err ← sticky error. Assert done for this cycle only. Next state is IDLE.
- start is ignored in ADD and DONE, with no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- Invalid digits: the arithmetic above is still applied unchanged (e.g. 15+15+1 gives digit 5, carry 0). The error is only flagged, never trapped.
- s, cout and err are registered. They hold their values from DONE until the next DONE. They do not change during ADD.
- The counter is max(1, clog2(DIGITS)) bits wide and never wraps past DIGITS−1.

## Timing
- Reset (rst_n=0, any time, including mid-ADD):
  - state goes to IDLE immediately.
  - busy=0, done=0, s=0, cout=0, err=0.
  - counter, carry, accumulator and operand registers are cleared.
  - An operation in progress is discarded, and no done is produced.
- Timeline, with start sampled high in IDLE at edge E0:
  - busy=1 from E0 through E0+DIGITS.
  - DONE is entered at edge E0+DIGITS; done=1 and s/cout/err are valid during that cycle.
  - done falls at edge E0+DIGITS+1.
- Latency from the start edge to the done edge is DIGITS cycles. The minimum start-to-start period is DIGITS+2 cycles.
- busy and done are never high in the same cycle.
- With DIGITS=1: ADD lasts one cycle, then DONE.

## Test plan
- DIGITS=3: a=0x100, b=0x225, cin=0 → done after 3 cycles of busy; s=0x325, cout=0, err=0.
- a=0x999, b=0x999, cin=0 → s=0x998, cout=1. Repeat with cin=1 → s=0x999, cout=1.
- a=0x000, b=0x000, cin=1 → s=0x001, cout=0. Then a=0x999, b=0x000, cin=1 → s=0x000, cout=1 (full carry ripple).
- Hold start=1 continuously from the first operation:
  - exactly one done every DIGITS+2 cycles.
  - operands changed while busy do not affect the in-flight result.
  - s stays stable between done pulses.
- Pull rst_n low after the second ADD cycle → all outputs 0 immediately and no done pulse. After release, a new start completes normally with the correct result.
- a=0x0F0, b=0x010, cin=0 → err=1 with done. s is computed per the rule above (digit1 = (15+1) > 9 → 22 → digit 6, carry 1 → s=0x160), cout=0. The next valid operation clears err.

Source files
------------

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one 1-digit add-and-correct slice is reused
// for every digit, least significant digit first, one digit per clock.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] s,
    output logic                cout,
    output logic                err,
    output logic [1:0]          dbg_state
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is sampled only in IDLE and never queued; busy is high
    // for exactly DIGITS cycles, then done pulses for one cycle with s/cout/err
    // valid. busy and done are never high together.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_c;
    logic            r_err_sticky;
    logic [W-1:0]    r_s;
    logic            r_cout;
    logic            r_err;

    logic [3:0]      w_ak;
    logic [3:0]      w_bk;
    logic [4:0]      w_t;
    logic [4:0]      w_u;
    logic            w_bad;
    logic            w_last;
    logic [W-1:0]    w_acc_next;

    assign w_ak   = r_a[3:0];
    assign w_bk   = r_b[3:0];
    assign w_t    = {1'b0, w_ak} + {1'b0, w_bk} + {4'b0000, r_c};
    // The +6 correction wraps modulo 32, which also defines invalid-digit results.
    assign w_u    = (w_t > 5'd9) ? (w_t + 5'd6) : w_t;
    assign w_bad  = (w_ak > 4'd9) || (w_bk > 4'd9);
    assign w_last = (r_cnt == CW'(DIGITS - 1));

    generate
        if (DIGITS > 1) begin : g_multi
            assign w_acc_next = {w_u[3:0], r_acc[W-1:4]};
        end else begin : g_single
            assign w_acc_next = w_u[3:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Results are loaded on the edge that enters DONE so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_c          <= 1'b0;
            r_err_sticky <= 1'b0;
            r_s          <= '0;
            r_cout       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_c          <= cin;
                        r_cnt        <= '0;
                        r_acc        <= '0;
                        r_err_sticky <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_a          <= r_a >> 4;
                    r_b          <= r_b >> 4;
                    r_acc        <= w_acc_next;
                    r_c          <= w_u[4];
                    r_err_sticky <= r_err_sticky | w_bad;
                    if (w_last) begin
                        r_s    <= w_acc_next;
                        r_cout <= w_u[4];
                        r_err  <= r_err_sticky | w_bad;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s         = r_s;
    assign cout      = r_cout;
    assign err       = r_err;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl: directed and random operands
// compared against a digit-by-digit arithmetic reference model.
module tb_bcd_serial_adder_ctrl;
  localparam int D  = 3;
  localparam int W  = 4 * D;
  localparam int P  = D + 2;
  localparam int RW = W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  s;
  logic          cout;
  logic          err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_res = '0;

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain decimal-digit arithmetic with the +6 correction taken mod 32.
  function automatic logic [RW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic ci);
    int c = int'(ci);
    int t;
    int ad;
    int bd;
    logic e = 1'b0;
    logic [W-1:0] sum = '0;
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    for (int k = 0; k < D; k++) begin
      sa = av >> (4 * k);
      sb = bv >> (4 * k);
      ad = int'(sa[3:0]);
      bd = int'(sb[3:0]);
      if (ad > 9 || bd > 9) e = 1'b1;
      t = ad + bd + c;
      if (t > 9) t = (t + 6) % 32;
      sum = sum | (W'(t % 16) << (4 * k));
      c = t / 16;
    end
    return {e, c[0], sum};
  endfunction

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] v = '0;
    int dg;
    for (int k = 0; k < D; k++) begin
      if (allow_bad && $urandom_range(0, 5) == 0) dg = $urandom_range(10, 15);
      else dg = $urandom_range(0, 9);
      v = v | (W'(dg) << (4 * k));
    end
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic [RW-1:0] exp_res);
    int nb = 0;
    bit seen = 0;
    logic [RW-1:0] res;
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < D + 4 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        seen = 1;
        res = exp_q.pop_front();
        check("latency", nb, D);
        check("s", 32'(s), 32'(res[W-1:0]));
        check("cout", 32'(cout), 32'(res[W]));
        check("err", 32'(err), 32'(res[W+1]));
        last_res = res;
      end else begin
        if (busy) nb++;
        check("hold_out", 32'({err, cout, s}), 32'(last_res));
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic [RW-1:0] res;
    int j;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'({err, cout, s}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(12'h100, 12'h225, 1'b0, {1'b0, 1'b0, 12'h325});
    run_op(12'h999, 12'h999, 1'b0, {1'b0, 1'b1, 12'h998});
    run_op(12'h999, 12'h999, 1'b1, {1'b0, 1'b1, 12'h999});
    run_op(12'h000, 12'h000, 1'b1, {1'b0, 1'b0, 12'h001});
    run_op(12'h999, 12'h000, 1'b1, {1'b0, 1'b1, 12'h000});
    run_op(12'h0F0, 12'h010, 1'b0, {1'b1, 1'b0, 12'h160});
    run_op(12'h123, 12'h456, 1'b0, {1'b0, 1'b0, 12'h579});
    run_op(12'h00F, 12'h00F, 1'b1, {1'b1, 1'b0, 12'h005});

    for (int n = 0; n < 20; n++) begin
      ra = rand_operand(1'b1);
      rb = rand_operand(1'b1);
      rc = 1'($urandom);
      run_op(ra, rb, rc, model(ra, rb, rc));
    end

    // start held high: one operation every P cycles, operands scrambled each cycle
    for (int i = 0; i <= 3 * P; i++) begin
      @(negedge clk);
      if (i > 0) begin
        j = i - 1;
        check("hold_done", 32'(done), 32'((j % P) == D));
        check("hold_busy", 32'(busy), 32'((j % P) < D));
        if (done) begin
          if (exp_q.size() == 0) begin
            check("hold_unexpected_done", 32'd1, 32'd0);
          end else begin
            res = exp_q.pop_front();
            check("hold_res", 32'({err, cout, s}), 32'(res));
            last_res = res;
          end
        end else begin
          check("hold_stable", 32'({err, cout, s}), 32'(last_res));
        end
      end
      if (i < 3 * P) begin
        start = 1'b1;
        a = rand_operand(1'b0);
        b = rand_operand(1'b0);
        cin = 1'($urandom);
        if (i % P == 0) exp_q.push_back(model(a, b, cin));
      end else begin
        start = 1'b0;
      end
    end
    check("hold_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // reset in the middle of ADD
    @(negedge clk);
    a = 12'h456; b = 12'h345; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_out", 32'({err, cout, s}), 32'd0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D + 3; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_no_busy", 32'(busy), 32'd0);
    end
    run_op(12'h458, 12'h347, 1'b1, {1'b0, 1'b0, 12'h806});
    ra = rand_operand(1'b0);
    rb = rand_operand(1'b0);
    run_op(ra, rb, 1'b0, model(ra, rb, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
